// File: rtl/if_agc.sv
// if_agc: IF-path automatic gain control that holds the windowed output peak at TARGET.
// Define IF_AGC_DC_BLOCK_EN to insert a first-order DC blocker (one extra en-cycle) ahead of the multiplier.
module if_agc #(
    parameter int DW       = 12,
    parameter int GW       = 16,
    parameter int GFRAC    = 12,
    parameter int WIN      = 256,
    parameter int TARGET   = 1024,
    parameter int TOL      = 64,
    parameter int K_ACQ    = 3,
    parameter int K_TRK    = 6,
    parameter int LOCK_CNT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 freeze,
    input  logic signed [DW-1:0] in,
    output logic signed [DW-1:0] out,
    output logic [GW-1:0]        gain,
    output logic                 locked
);

    localparam int PW   = DW + GW + 1;
    localparam int CW   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int LW   = $clog2(LOCK_CNT + 1);
    localparam int S_HI = 2**(DW-1) - 1;
    localparam int S_LO = -(2**(DW-1));

    typedef enum logic {ACQ, TRACK} state_t;

    state_t               state, state_n;
    logic [LW-1:0]        lock_cnt, lock_cnt_n;
    logic [GW-1:0]        gain_n, step, g_dn;
    logic [GW:0]          g_up;
    logic [CW-1:0]        cnt;
    logic [DW-2:0]        run_max, mag, pk;
    logic signed [DW-1:0] x, out_n;
    logic signed [PW-1:0] prod_q, scaled;
    logic                 win_end, in_tol, in_wide;

`ifdef IF_AGC_DC_BLOCK_EN
    localparam int AW = DW + 8;
    logic signed [AW-1:0] acc, diff;
    logic signed [DW-1:0] x_q, x_n;

    // acc tracks 256x the running mean; diff is the DC-free sample before saturation.
    always_comb begin
        diff = AW'(in) - (acc >>> 8);
        if (diff > AW'(S_HI))      x_n = DW'(S_HI);
        else if (diff < AW'(S_LO)) x_n = DW'(S_LO);
        else                       x_n = diff[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            x_q <= '0;
        end else if (en) begin
            acc <= acc + diff;
            x_q <= x_n;
        end
    end

    assign x = x_q;
`else
    assign x = in;
`endif

    // Saturating rescale and symmetric magnitude (the most negative code reads as full scale).
    always_comb begin
        scaled = prod_q >>> GFRAC;
        if (scaled > PW'(S_HI))      out_n = DW'(S_HI);
        else if (scaled < PW'(S_LO)) out_n = DW'(S_LO);
        else                         out_n = scaled[DW-1:0];

        if (out == DW'(S_LO))  mag = (DW-1)'(S_HI);
        else if (out[DW-1])    mag = (DW-1)'(-out);
        else                   mag = (DW-1)'(out);

        pk      = (mag > run_max) ? mag : run_max;
        win_end = en && (cnt == CW'(WIN - 1));
        in_tol  = (int'(pk) >= TARGET - TOL) && (int'(pk) <= TARGET + TOL);
        in_wide = (int'(pk) >= TARGET - 4*TOL) && (int'(pk) <= TARGET + 4*TOL);
    end

    always_comb begin
        step = (state == TRACK) ? (gain >> K_TRK) : (gain >> K_ACQ);
        if (step == '0) step = GW'(1);
        g_up = {1'b0, gain} + {1'b0, step};
        g_dn = gain - step;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing branch would infer a latch.
        state_n    = state;
        lock_cnt_n = lock_cnt;
        gain_n     = gain;
        if (win_end && !freeze) begin
            if (int'(pk) > TARGET + TOL)      gain_n = (g_dn == '0) ? GW'(1) : g_dn;
            else if (int'(pk) < TARGET - TOL) gain_n = g_up[GW] ? '1 : g_up[GW-1:0];

            case (state)
                ACQ: begin
                    if (!in_tol) begin
                        lock_cnt_n = '0;
                    end else if (lock_cnt == LW'(LOCK_CNT - 1)) begin
                        state_n    = TRACK;
                        lock_cnt_n = '0;
                    end else begin
                        lock_cnt_n = lock_cnt + LW'(1);
                    end
                end
                TRACK:   if (!in_wide) state_n = ACQ;
                default: state_n = ACQ;
            endcase
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACQ;
            lock_cnt <= '0;
            gain     <= GW'(2**GFRAC);
        end else if (en) begin
            state    <= state_n;
            lock_cnt <= lock_cnt_n;
            gain     <= gain_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            out     <= '0;
            cnt     <= '0;
            run_max <= '0;
        end else if (en) begin
            prod_q <= PW'(x) * PW'($signed({1'b0, gain}));
            out    <= out_n;
            if (cnt == CW'(WIN - 1)) begin
                cnt     <= '0;
                run_max <= '0;
            end else begin
                cnt     <= cnt + CW'(1);
                run_max <= pk;
            end
        end
    end

    assign locked = (state == TRACK);

endmodule
